// File: rtl/signed_bcd_if.sv
// Handshake and digit bundle between the signed adder, the BCD converter
// and the seven-segment decoders.
interface signed_bcd_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             neg;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (
    output start, result,
    input  busy, done, neg,
    input  hundreds, tens, ones
  );

  modport slave (
    input  start, result,
    output busy, done, neg,
    output hundreds, tens, ones
  );
endinterface

// File: rtl/signed_bcd_converter.sv
// Sequential double-dabble: signed WIDTH-bit sum -> sign + 3 BCD digits,
// one magnitude bit per clock, start/busy/done handshake.
module signed_bcd_converter #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  signed_bcd_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           state, state_n;
  logic             neg_p, neg_p_n;
  logic [WIDTH-1:0] mag, mag_n, mag_in;
  logic [11:0]      bcd, bcd_n, bcd_adj, bcd_sh;
  logic [3:0]       cnt, cnt_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             neg_q, neg_n;
  logic [3:0]       hun_q, hun_n;
  logic [3:0]       ten_q, ten_n;
  logic [3:0]       one_q, one_n;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // -2^(WIDTH-1) negates to itself, read back as the unsigned 2^(WIDTH-1)
  assign mag_in = bus.result[WIDTH-1]
                ? ~bus.result + WIDTH'(1)
                : bus.result;

  assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};
  assign bcd_sh  = {bcd_adj[10:0], mag[WIDTH-1]};

  always_comb begin
    state_n = state;
    neg_p_n = neg_p;
    mag_n   = mag;
    bcd_n   = bcd;
    cnt_n   = cnt;
    busy_n  = busy_q;
    done_n  = 1'b0;
    neg_n   = neg_q;
    hun_n   = hun_q;
    ten_n   = ten_q;
    one_n   = one_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          neg_p_n = bus.result[WIDTH-1];
          mag_n   = mag_in;
          bcd_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bcd_n = bcd_sh;
        mag_n = {mag[WIDTH-2:0], 1'b0};
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          hun_n   = bcd_sh[11:8];
          ten_n   = bcd_sh[7:4];
          one_n   = bcd_sh[3:0];
          neg_n   = neg_p;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      neg_p  <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      hun_q  <= '0;
      ten_q  <= '0;
      one_q  <= '0;
    end else begin
      state  <= state_n;
      neg_p  <= neg_p_n;
      mag    <= mag_n;
      bcd    <= bcd_n;
      cnt    <= cnt_n;
      busy_q <= busy_n;
      done_q <= done_n;
      neg_q  <= neg_n;
      hun_q  <= hun_n;
      ten_q  <= ten_n;
      one_q  <= one_n;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.neg      = neg_q;
  assign bus.hundreds = hun_q;
  assign bus.tens     = ten_q;
  assign bus.ones     = one_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed plus randomized bench for signed_bcd_converter against an
// arithmetic sign/magnitude/decimal-digit reference model.
module tb_signed_bcd_converter;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  logic [12:0] last = '0;

  signed_bcd_if #(.WIDTH(WIDTH)) bif ();

  signed_bcd_converter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] model(input logic [7:0] v);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return {(s < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [12:0] outs();
    return {bif.neg, bif.hundreds, bif.tens, bif.ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_conv(input logic [7:0] v, input bit noise);
    int  n;
    bit  got;
    logic [12:0] exp;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.result = v;
    @(negedge clk);
    bif.start = 1'b0;
    exp = model(v);
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bif.done) begin
        bif.start = 1'b0;
        got = 1'b1;
        break;
      end
      if (bif.busy) n++;
      check("hold", 32'(outs()), 32'(last));
      if (noise) begin
        bif.result = 8'($urandom);
        bif.start  = 1'($urandom);
      end
      @(negedge clk);
    end
    bif.start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(n), 32'(WIDTH));
    check($sformatf("conv_%02h", v), 32'(outs()), 32'(exp));
    last = exp;
    @(negedge clk);
    check("done_pulse", 32'(bif.done), 32'd0);
    check("idle_busy", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int  gap;
    bit  saw;
    int  off;
    logic [7:0] v;

    bif.start  = 1'b0;
    bif.result = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    run_conv(8'h07, 1'b0);
    run_conv(8'hF1, 1'b0);
    run_conv(8'h80, 1'b0);
    run_conv(8'h7F, 1'b0);

    // abort mid-conversion
    @(negedge clk);
    bif.start  = 1'b1;
    bif.result = 8'h9C;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_done", 32'(bif.done), 32'd0);
    check("abort_outs", 32'(outs()), 32'd0);
    last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bif.done) saw = 1'b1;
    end
    check("abort_no_done", 32'(saw), 32'd0);

    // start/result noise during busy is ignored and not queued
    run_conv(8'h9C, 1'b1);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bif.done || bif.busy) saw = 1'b1;
    end
    check("no_queue", 32'(saw), 32'd0);

    // start held high: back-to-back conversions
    @(negedge clk);
    bif.start  = 1'b1;
    bif.result = 8'hFF;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bif.done) begin
        saw = 1'b1;
        break;
      end
    end
    check("b2b_first", 32'(saw), 32'd1);
    check("b2b_ff", 32'(outs()), 32'(model(8'hFF)));
    bif.result = 8'h00;
    gap = 0;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      gap++;
      if (bif.done) begin
        saw = 1'b1;
        break;
      end
    end
    bif.start = 1'b0;
    check("b2b_second", 32'(saw), 32'd1);
    check("b2b_gap", 32'(gap), 32'(WIDTH + 1));
    check("b2b_zero", 32'(outs()), 32'(model(8'h00)));
    last = model(8'h00);
    repeat (WIDTH + 2) @(negedge clk);

    // every value once, in a random odd-stride order, with noise
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      v = 8'((i * 167) + off);
      run_conv(v, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
